// File: rtl/sdram_arb2.sv
// sdram_arb2 -- two-master round-robin arbiter in front of a single-port
// SDRAM controller. One access is in flight at a time. The winning request is
// latched into registered mem_* outputs and held until the controller
// completes it. The result then returns to the winning master as a
// one-cycle ready pulse.
//
// Ports:
//   clk, resetn                 system clock, synchronous active-low reset
//   m0_addr/din/wmask/valid     master 0 (CPU) request, wmask==0 is a read
//   m0_dout, m0_ready           master 0 read data, completion pulse
//   m1_addr/din/wmask/valid     master 1 (DMA/video) request
//   m1_dout, m1_ready           master 1 read data, completion pulse
//   mem_addr/din/wmask/valid    registered request to the SDRAM controller
//   mem_dout, mem_ready         controller data and completion; mem_ready is
//                               held high during controller init
module sdram_arb2 #(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_din,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_valid,
  output logic [31:0]       m0_dout,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_din,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_valid,
  output logic [31:0]       m1_dout,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_wmask,
  output logic              mem_valid,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_BUSY      = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              last_grant_r, last_grant_s;
  logic              grant_r, grant_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [31:0]       mem_din_r, mem_din_s;
  logic [3:0]        mem_wmask_r, mem_wmask_s;
  logic              mem_valid_r, mem_valid_s;
  logic [31:0]       m0_dout_r, m0_dout_s;
  logic [31:0]       m1_dout_r, m1_dout_s;
  logic              m0_ready_r, m0_ready_s;
  logic              m1_ready_r, m1_ready_s;
  logic              elig0_s, elig1_s;

  // A master's own ready pulse masks its still-asserted valid for that cycle.
  assign elig0_s = m0_valid & ~m0_ready_r;
  assign elig1_s = m1_valid & ~m1_ready_r;

  assign mem_addr  = mem_addr_r;
  assign mem_din   = mem_din_r;
  assign mem_wmask = mem_wmask_r;
  assign mem_valid = mem_valid_r;
  assign m0_dout   = m0_dout_r;
  assign m1_dout   = m1_dout_r;
  assign m0_ready  = m0_ready_r;
  assign m1_ready  = m1_ready_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_WAIT_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and grant registers; last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_din_r    <= 32'h0000_0000;
      mem_wmask_r  <= 4'h0;
      mem_valid_r  <= 1'b0;
      m0_dout_r    <= 32'h0000_0000;
      m1_dout_r    <= 32'h0000_0000;
      m0_ready_r   <= 1'b0;
      m1_ready_r   <= 1'b0;
    end else begin
      last_grant_r <= last_grant_s;
      grant_r      <= grant_s;
      mem_addr_r   <= mem_addr_s;
      mem_din_r    <= mem_din_s;
      mem_wmask_r  <= mem_wmask_s;
      mem_valid_r  <= mem_valid_s;
      m0_dout_r    <= m0_dout_s;
      m1_dout_r    <= m1_dout_s;
      m0_ready_r   <= m0_ready_s;
      m1_ready_r   <= m1_ready_s;
    end
  end

  // Next-state and next-register logic; ready pulses default low so they last one cycle.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    grant_s      = grant_r;
    mem_addr_s   = mem_addr_r;
    mem_din_s    = mem_din_r;
    mem_wmask_s  = mem_wmask_r;
    mem_valid_s  = mem_valid_r;
    m0_dout_s    = m0_dout_r;
    m1_dout_s    = m1_dout_r;
    m0_ready_s   = 1'b0;
    m1_ready_s   = 1'b0;

    case (state_r)
      ST_WAIT_INIT: begin
        // mem_ready is high for the whole controller init; its first low
        // cycle marks the controller as ready for traffic.
        mem_valid_s = 1'b0;
        if (!mem_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_INIT;
        end
      end

      ST_IDLE: begin
        if (elig0_s || elig1_s) begin
          if (elig0_s && elig1_s) begin
            grant_s = ~last_grant_r;
          end else if (elig1_s) begin
            grant_s = 1'b1;
          end else begin
            grant_s = 1'b0;
          end
          if (grant_s) begin
            mem_addr_s  = m1_addr;
            mem_din_s   = m1_din;
            mem_wmask_s = m1_wmask;
          end else begin
            mem_addr_s  = m0_addr;
            mem_din_s   = m0_din;
            mem_wmask_s = m0_wmask;
          end
          mem_valid_s = 1'b1;
          state_s     = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          mem_valid_s  = 1'b0;
          last_grant_s = grant_r;
          if (grant_r) begin
            m1_dout_s  = mem_dout;
            m1_ready_s = 1'b1;
          end else begin
            m0_dout_s  = mem_dout;
            m0_ready_s = 1'b1;
          end
          state_s = ST_RESP;
        end else begin
          state_s = ST_BUSY;
        end
      end

      ST_RESP: begin
        // One cycle with mem_valid low before the next arbitration.
        state_s = ST_IDLE;
      end

      default: begin
        mem_valid_s = 1'b0;
        state_s     = ST_WAIT_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arb2.sv
module tb_sdram_arb2;

  localparam int ADDR_W = 25;

  logic              clk;
  logic              resetn;
  logic [ADDR_W-1:0] m0_addr, m1_addr, mem_addr;
  logic [31:0]       m0_din, m1_din, mem_din;
  logic [3:0]        m0_wmask, m1_wmask, mem_wmask;
  logic              m0_valid, m1_valid, mem_valid;
  logic [31:0]       m0_dout, m1_dout, mem_dout;
  logic              m0_ready, m1_ready, mem_ready;

  int   checks;
  int   errors;
  int   resp_lat;
  int   wait_cnt;
  logic init_hold;
  logic resp_pulse;
  logic [31:0] resp_data;

  // Controller model: init-time ready level plus a completion pulse
  // resp_lat+1 cycles after mem_valid is seen; data is junk outside the pulse.
  assign mem_ready = init_hold | resp_pulse;
  assign mem_dout  = resp_pulse ? resp_data : 32'h5A5A_5A5A;

  sdram_arb2 #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_wmask(m0_wmask), .m0_valid(m0_valid),
    .m0_dout(m0_dout), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_wmask(m1_wmask), .m1_valid(m1_valid),
    .m1_dout(m1_dout), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wmask(mem_wmask), .mem_valid(mem_valid),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion responder.
  initial begin
    resp_pulse = 1'b0;
    wait_cnt   = 0;
    forever begin
      tick();
      if (resp_pulse) begin
        resp_pulse = 1'b0;
        wait_cnt   = 0;
      end else if (mem_valid === 1'b1) begin
        if (wait_cnt >= resp_lat) begin
          resp_pulse = 1'b1;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Ticks until the given port's ready is seen; n=0 on timeout.
  task automatic wait_ready(input logic port, output int n, output logic other);
    logic got;
    got = 1'b0; n = 0; other = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if ((port == 1'b0) ? (m0_ready === 1'b1) : (m1_ready === 1'b1)) got = 1'b1;
      if ((port == 1'b0) ? (m1_ready === 1'b1) : (m0_ready === 1'b1)) other = 1'b1;
    end
    if (!got) n = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; init_hold = 1'b1;
    m0_valid = 1'b1; m0_addr = 25'h0000040; m0_din = 32'h0; m0_wmask = 4'h0;
    tick(); tick();
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
    checks++;
    if (mem_addr !== 25'h0 || mem_din !== 32'h0 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h/%h/%h expected 0/0/0", mem_addr, mem_din, mem_wmask);
    end
    checks++;
    if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", m0_ready, m1_ready);
    end
    checks++;
    if (m0_dout !== 32'h0 || m1_dout !== 32'h0) begin
      errors++; $display("FAIL reset_dout: got %h/%h expected 0/0", m0_dout, m1_dout);
    end
  endtask

  task automatic test_init();
    int bad; int n; logic found; logic other;
    bad = 0;
    resetn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mem_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL init_no_request: got %0d cycles with mem_valid expected 0", bad); end
    init_hold = 1'b0;
    resp_data = 32'hA5A5_0001;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      tick();
      if (mem_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || mem_addr !== 25'h0000040) begin
      errors++; $display("FAIL init_first_grant: got valid=%b addr=%h expected 1/0000040", found, mem_addr);
    end
    wait_ready(1'b0, n, other);
    m0_valid = 1'b0;
    checks++;
    if (n == 0 || m0_dout !== 32'hA5A5_0001) begin
      errors++; $display("FAIL init_complete: got n=%0d dout=%h expected ready and a5a50001", n, m0_dout);
    end
    tick();
  endtask

  task automatic test_single_read();
    int n; logic other;
    m0_addr = 25'h0000100; m0_din = 32'h0; m0_wmask = 4'h0; m0_valid = 1'b1;
    resp_data = 32'hDEAD_BEEF; resp_lat = 2;
    tick();
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 25'h0000100 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL read_grant: got v=%b a=%h m=%h expected 1/0000100/0", mem_valid, mem_addr, mem_wmask);
    end
    checks++;
    if (m0_dout !== 32'hA5A5_0001) begin errors++; $display("FAIL read_dout_hold: got %h expected a5a50001", m0_dout); end
    wait_ready(1'b0, n, other);
    m0_valid = 1'b0;
    checks++;
    if (n != 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", n); end
    checks++;
    if (m0_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", m0_dout); end
    checks++;
    if (other !== 1'b0) begin errors++; $display("FAIL read_m1_quiet: got %b expected 0", other); end
    tick();
    checks++;
    if (m0_ready !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL read_pulse_width: got ready=%b valid=%b expected 0/0", m0_ready, mem_valid);
    end
  endtask

  task automatic test_write();
    int bad; int vcyc; int n; logic got; logic m0_seen;
    m1_addr = 25'h1FFFFFC; m1_din = 32'h1234_5678; m1_wmask = 4'b0011; m1_valid = 1'b1;
    resp_data = 32'hCAFE_F00D; resp_lat = 3;
    bad = 0; vcyc = 0; n = 0; got = 1'b0; m0_seen = 1'b0;
    while (!got && n < 30) begin
      tick(); n++;
      if (m0_ready === 1'b1) m0_seen = 1'b1;
      if (m1_ready === 1'b1) begin
        got = 1'b1;
      end else if (mem_valid === 1'b1) begin
        vcyc++;
        if (mem_addr !== 25'h1FFFFFC || mem_din !== 32'h1234_5678 || mem_wmask !== 4'b0011) bad++;
      end
    end
    m1_valid = 1'b0;
    checks++;
    if (bad != 0 || vcyc != 4) begin errors++; $display("FAIL write_bus: got %0d bad of %0d valid cycles expected 0 of 4", bad, vcyc); end
    checks++;
    if (!got || m1_dout !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_done: got ready=%b dout=%h expected 1/cafef00d", got, m1_dout); end
    checks++;
    if (m0_seen !== 1'b0 || m0_dout !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_m0_untouched: got ready_seen=%b dout=%h expected 0/deadbeef", m0_seen, m0_dout);
    end
    tick();
    checks++;
    if (m1_ready !== 1'b0) begin errors++; $display("FAIL write_pulse_width: got %b expected 0", m1_ready); end
  endtask

  task automatic test_stability();
    int bad; int vcyc; int n; logic got;
    m0_addr = 25'h0000200; m0_din = 32'h1111_2222; m0_wmask = 4'hF; m0_valid = 1'b1;
    resp_data = 32'h0000_7777; resp_lat = 4;
    tick();
    bad = 0; vcyc = 0; n = 0; got = 1'b0;
    if (mem_valid === 1'b1) vcyc++;
    if (mem_addr !== 25'h0000200 || mem_din !== 32'h1111_2222) bad++;
    while (!got && n < 30) begin
      m0_addr = ~m0_addr; m0_din = ~m0_din;
      tick(); n++;
      if (m0_ready === 1'b1) begin
        got = 1'b1;
      end else if (mem_valid === 1'b1) begin
        vcyc++;
        if (mem_addr !== 25'h0000200 || mem_din !== 32'h1111_2222 || mem_wmask !== 4'hF) bad++;
      end
    end
    m0_valid = 1'b0;
    checks++;
    if (bad != 0 || vcyc != 5) begin errors++; $display("FAIL stability: got %0d bad of %0d valid cycles expected 0 of 5", bad, vcyc); end
    checks++;
    if (!got || m0_dout !== 32'h0000_7777) begin errors++; $display("FAIL stability_done: got ready=%b dout=%h expected 1/00007777", got, m0_dout); end
    tick();
  endtask

  task automatic test_contention();
    int cnt; int bad; logic prev0; logic prev1;
    logic order [4];
    resetn = 1'b0; init_hold = 1'b1;
    m0_addr = 25'h0000010; m0_wmask = 4'h0; m0_valid = 1'b1;
    m1_addr = 25'h0000020; m1_wmask = 4'h0; m1_valid = 1'b1;
    resp_lat = 1; resp_data = 32'h0C0C_0C0C;
    for (int k = 0; k < 4; k++) order[k] = 1'bx;
    tick(); tick();
    resetn = 1'b1;
    tick();
    init_hold = 1'b0;
    cnt = 0; bad = 0; prev0 = 1'b0; prev1 = 1'b0;
    for (int i = 0; i < 80 && cnt < 4; i++) begin
      tick();
      if (m0_ready === 1'b1 && m1_ready === 1'b1) bad++;
      if (m0_ready === 1'b1 && prev0) bad++;
      if (m1_ready === 1'b1 && prev1) bad++;
      if (m0_ready === 1'b1 && !prev0) begin order[cnt] = 1'b0; cnt++; end
      else if (m1_ready === 1'b1 && !prev1) begin order[cnt] = 1'b1; cnt++; end
      prev0 = m0_ready; prev1 = m1_ready;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();
    if (m0_ready !== 1'b0 || m1_ready !== 1'b0) bad++;
    checks++;
    if (cnt != 4) begin errors++; $display("FAIL contention_count: got %0d expected 4", cnt); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL contention_pulses: got %0d width/overlap faults expected 0", bad); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (order[k] !== k[0]) begin errors++; $display("FAIL contention_order%0d: got %b expected %b", k, order[k], k[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int bad; int n; logic other;
    m0_addr = 25'h0000300; m0_wmask = 4'h0; m0_valid = 1'b1; m1_valid = 1'b0;
    resp_lat = 10; resp_data = 32'h9999_0000;
    tick();
    checks++;
    if (mem_valid !== 1'b1) begin errors++; $display("FAIL rmid_grant: got %b expected 1", mem_valid); end
    tick(); tick();
    resetn = 1'b0; init_hold = 1'b1;
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 25'h0 || mem_din !== 32'h0 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL rmid_mem_clear: got %b/%h/%h/%h expected 0/0/0/0", mem_valid, mem_addr, mem_din, mem_wmask);
    end
    checks++;
    if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_dout !== 32'h0 || m1_dout !== 32'h0) begin
      errors++; $display("FAIL rmid_master_clear: got %b%b %h/%h expected 00 0/0", m0_ready, m1_ready, m0_dout, m1_dout);
    end
    tick();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rmid_wait_init: got %0d active cycles expected 0", bad); end
    init_hold = 1'b0;
    wait_ready(1'b0, n, other);
    m0_valid = 1'b0;
    checks++;
    if (n == 0 || other !== 1'b0 || m0_dout !== 32'h9999_0000) begin
      errors++; $display("FAIL rmid_restart: got n=%0d other=%b dout=%h expected ready/0/99990000", n, other, m0_dout);
    end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0; init_hold = 1'b1; resp_lat = 2; resp_data = 32'h0;
    m0_addr = 25'h0; m0_din = 32'h0; m0_wmask = 4'h0; m0_valid = 1'b0;
    m1_addr = 25'h0; m1_din = 32'h0; m1_wmask = 4'h0; m1_valid = 1'b0;
    test_reset();
    test_init();
    test_single_read();
    test_write();
    test_stability();
    test_contention();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_arb2.md
SDRAM_ARB2 -- requirements
Module: sdram_arb2

Interface
REQ-001 Parameter ADDR_W, default 25, is the word/byte address width shared by both masters and the SDRAM controller port.
REQ-002 clk  input  1  system clock, the same clock that drives the SDRAM controller.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 m0_addr, m0_din, m0_wmask, m0_valid  input  ADDR_W/32/4/1  master 0 (CPU) request; wmask==0 means read.
REQ-005 m0_dout, m0_ready  output  32/1  master 0 read data and one-cycle completion pulse.
REQ-006 m1_addr, m1_din, m1_wmask, m1_valid  input  ADDR_W/32/4/1  master 1 (DMA/video) request; same encoding as master 0.
REQ-007 m1_dout, m1_ready  output  32/1  master 1 read data and completion pulse.
REQ-008 mem_addr, mem_din, mem_wmask, mem_valid  output  ADDR_W/32/4/1  registered request to the SDRAM controller.
REQ-009 mem_dout, mem_ready  input  32/1  controller read data and completion; mem_ready is high throughout controller init and is a one-cycle pulse per completed access afterwards.

Function
REQ-010 The block SHALL implement a state machine with states WAIT_INIT, IDLE, BUSY and RESP.
REQ-011 WAIT_INIT: the block SHALL issue no request and SHALL move to IDLE on the first cycle mem_ready is sampled low, so that init-time mem_ready is never taken as a completion.
REQ-012 In IDLE, port N SHALL be eligible when mN_valid=1 and mN_ready=0 in that cycle; the mN_ready=0 condition masks a master's stale valid in the cycle after its own completion.
REQ-013 When exactly one port is eligible in IDLE, the block SHALL grant that port.
REQ-014 When both ports are eligible, the block SHALL grant the port not equal to last_grant (round-robin).
REQ-015 On grant, the block SHALL latch the winner's addr, din and wmask into mem_addr, mem_din and mem_wmask, set mem_valid=1 on the next cycle, record the grant, and enter BUSY.
REQ-016 mem_addr, mem_din, mem_wmask and mem_valid SHALL stay constant throughout BUSY, independent of master inputs.
REQ-017 In BUSY, on the cycle mem_ready is sampled 1, the block SHALL clear mem_valid on the following edge, capture mem_dout into the granted port's mN_dout, assert that port's mN_ready for exactly one cycle, update last_grant, and enter RESP.
REQ-018 RESP SHALL last exactly one cycle and then return to IDLE unconditionally; this gives the controller one cycle with mem_valid=0 before re-arbitration.
REQ-019 mN_dout SHALL be updated only on completions for port N, for writes as well as reads, and SHALL hold its value otherwise.
REQ-020 The non-granted port's ready SHALL remain 0 during an access.
REQ-021 A master SHALL hold its request stable until its ready pulse; a valid dropped before grant is simply not served.
REQ-022 Latency: the grant decision is made in cycle T, mem_valid=1 from T+1, and mN_ready=1 one cycle after mem_ready is sampled 1.
REQ-023 A port SHALL be re-grantable no earlier than 2 cycles after its ready pulse (RESP plus the REQ-012 mask).
REQ-024 mem_ready high in IDLE or RESP SHALL be ignored.
REQ-025 At most one access SHALL be outstanding; there is no buffering or queuing beyond the latched request.

Reset
REQ-026 While resetn=0 at a clk edge: state=WAIT_INIT, mem_valid=0, mem_addr/mem_din/mem_wmask=0, m0_ready=m1_ready=0, m0_dout=m1_dout=0, last_grant=1 (master 0 wins the first tie).
REQ-027 Reset asserted mid-access SHALL abandon the outstanding request with no ready pulse to either master; after reset, arbitration SHALL restart from WAIT_INIT.

Verification
REQ-028 Init: hold mem_ready=1 for 200 cycles with m0_valid=1 -> mem_valid stays 0; mem_ready drops -> mem_valid=1 within 2 cycles with m0's address.
REQ-029 Single read: m0 reads addr 0x0000100; model returns mem_dout=0xDEADBEEF with a ready pulse -> m0_ready pulses once with m0_dout=0xDEADBEEF, and m1_ready stays 0.
REQ-030 Contention: both masters hold valid continuously with the first tie after reset -> grant order 0,1,0,1 across four accesses, and each mN_ready is exactly one cycle.
REQ-031 Write passthrough: m1 writes din=0x12345678, wmask=4'b0011, addr=0x1FFFFFC -> mem_* carries exactly those values until mem_ready; m1_ready pulses once.
REQ-032 Stability: toggle m0_addr and m0_din every cycle during BUSY -> mem_addr and mem_din remain at the latched values.
REQ-033 Reset mid-access: assert resetn=0 two cycles after mem_valid rises -> all outputs take REQ-026 values next edge, no mN_ready pulse, and the block re-enters WAIT_INIT.
